// File: rtl/mem_access_ctrl_if.sv
// Pipeline/memory-side signal bundle for mem_access_ctrl.
// slave is the controller's view; master is the pipeline plus data memory.
interface mem_access_ctrl_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic        m_re;
  logic [31:0] m_pc;
  logic [31:0] m_rdata;

  modport master (
    output req, op, addr, wdata, pc, m_rdata,
    input  busy, done, rdata, addr_err, m_addr, m_wdata, m_we, m_re, m_pc
  );

  modport slave (
    input  req, op, addr, wdata, pc, m_rdata,
    output busy, done, rdata, addr_err, m_addr, m_wdata, m_we, m_re, m_pc
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller adding byte/halfword access and alignment/range checks
// on top of a word-only memory with combinational read and synchronous write.
module mem_access_ctrl #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input logic              clk,
  input logic              Reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLb  = 3'd1;
  localparam logic [2:0] OpLbu = 3'd2;
  localparam logic [2:0] OpLh  = 3'd3;
  localparam logic [2:0] OpLhu = 3'd4;
  localparam logic [2:0] OpSw  = 3'd5;
  localparam logic [2:0] OpSb  = 3'd6;
  localparam logic [2:0] OpSh  = 3'd7;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [31:0] word_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic        addr_err_q;

  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic        sub_store;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] store_word;

  // Request checks look at the live inputs so an error can skip memory entirely.
  always_comb begin
    misaligned = 1'b0;
    case (bus.op)
      OpLw, OpSw:        misaligned = (bus.addr[1:0] != 2'b00);
      OpLh, OpLhu, OpSh: misaligned = bus.addr[0];
      default:           misaligned = 1'b0;
    endcase
    out_of_range = ({2'b00, bus.addr[31:2]} >= MEM_WORDS);
    req_err      = misaligned | out_of_range;
  end

  assign sub_store = (op_q == OpSb) || (op_q == OpSh);

  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_byte = bus.m_rdata[7:0];
      2'd1:    lane_byte = bus.m_rdata[15:8];
      2'd2:    lane_byte = bus.m_rdata[23:16];
      default: lane_byte = bus.m_rdata[31:24];
    endcase
    lane_half = addr_q[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    load_val  = bus.m_rdata;
    case (op_q)
      OpLb:    load_val = {{24{lane_byte[7]}}, lane_byte};
      OpLbu:   load_val = {24'h000000, lane_byte};
      OpLh:    load_val = {{16{lane_half[15]}}, lane_half};
      OpLhu:   load_val = {16'h0000, lane_half};
      default: load_val = bus.m_rdata;
    endcase
  end

  // Read-modify-write merge; sw bypasses the read word entirely.
  always_comb begin
    store_word = word_q;
    case (op_q)
      OpSb: begin
        case (addr_q[1:0])
          2'd0:    store_word[7:0]   = wdata_q[7:0];
          2'd1:    store_word[15:8]  = wdata_q[7:0];
          2'd2:    store_word[23:16] = wdata_q[7:0];
          default: store_word[31:24] = wdata_q[7:0];
        endcase
      end
      OpSh: begin
        if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
        else           store_word[15:0]  = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      op_q       <= 3'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      pc_q       <= 32'h0;
      word_q     <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req) begin
            op_q       <= bus.op;
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
            pc_q       <= bus.pc;
            addr_err_q <= req_err;
            busy_q     <= 1'b1;
            if (req_err) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (bus.op == OpSw) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          word_q <= bus.m_rdata;
          if (sub_store) begin
            state_q <= StWr;
          end else begin
            rdata_q <= load_val;
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StWr: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.addr_err = addr_err_q;
  assign bus.m_addr   = {addr_q[31:2], 2'b00};
  assign bus.m_wdata  = store_word;
  // Gate on Reset so a reset landing in WR never commits a write.
  assign bus.m_we     = (state_q == StWr) & ~Reset;
  assign bus.m_re     = (state_q == StRd);
  assign bus.m_pc     = pc_q;

endmodule
